// File: rtl/axis_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module  : axis_fifo_drain
// Brief   : Drains a FWFT FIFO into an AXI-Stream master in fixed-length
//           packets, gated by enable at packet boundaries.
// Revision: 1.0 - initial release
// ============================================================================
module axis_fifo_drain #(
    parameter int DATA_W  = 14,
    parameter int PKT_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              busy
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_RUN    = 1'b1;
    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [7:0] beat_cnt;
    logic       handshake;
    logic       out_free;
    logic       pkt_open;
    logic       load;
    logic       beat_last;

    assign handshake = m_axis_tvalid & m_axis_tready;
    assign out_free  = ~m_axis_tvalid | m_axis_tready;
    // A packet already under way always finishes; a new one needs enable.
    assign pkt_open  = (beat_cnt != 8'd0) | enable;
    assign load      = (state == S_RUN) & ~fifo_empty & out_free & pkt_open;
    assign beat_last = (beat_cnt == LAST_IDX);

    assign fifo_rd_en = load;
    assign busy       = (state == S_RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (enable) state_nxt = S_RUN;
            S_RUN:  if (handshake & m_axis_tlast & ~enable) state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= 8'd0;
        end else if (load) begin
            beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    // Output register: a load wins over a plain handshake, giving 1 beat/cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= fifo_rd_data;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= beat_last;
        end else if (handshake) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (handshake & m_axis_tlast) begin
            pkt_count <= pkt_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/axis_fifo_drain.md
AXIS_FIFO_DRAIN -- requirements
Module: axis_fifo_drain

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 14, giving the FIFO word and tdata width.
REQ-002 The block SHALL have parameter PKT_LEN, default 16, giving beats per packet; legal range 1..255.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the pkt_count width.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-006 The block SHALL have port enable, input, 1, which starts and stops streaming at packet boundaries.
REQ-007 The block SHALL have port fifo_empty, input, 1, the FIFO empty flag.
REQ-008 The block SHALL have port fifo_rd_data, input, DATA_W, the FIFO head word (first-word-fall-through, valid while fifo_empty=0).
REQ-009 The block SHALL have port fifo_rd_en, output, 1, which pops the FIFO head at the clock edge.
REQ-010 The block SHALL have port m_axis_tdata, output, DATA_W, the stream data.
REQ-011 The block SHALL have port m_axis_tvalid, output, 1, the stream valid.
REQ-012 The block SHALL have port m_axis_tready, input, 1, the downstream ready.
REQ-013 The block SHALL have port m_axis_tlast, output, 1, which marks the last beat of a packet.
REQ-014 The block SHALL have port pkt_count, output, CNT_W, the count of completed packets.
REQ-015 The block SHALL have port busy, output, 1, which is high while the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE and RUN.
REQ-017 IDLE->RUN SHALL occur on the first clock with enable=1.
REQ-018 In RUN, a beat handshake with m_axis_tlast=1 SHALL return the FSM to IDLE if enable=0 in that cycle; otherwise the FSM SHALL stay in RUN.
REQ-019 The load condition SHALL be: state=RUN and fifo_empty=0 and (m_axis_tvalid=0 or m_axis_tready=1) and the packet is not yet fully loaded.
REQ-020 fifo_rd_en SHALL equal the load condition, combinationally, and SHALL never assert while fifo_empty=1.
REQ-021 On load, m_axis_tdata<=fifo_rd_data and m_axis_tvalid<=1 SHALL occur at the same edge as the pop; first-beat latency from a non-empty FIFO entering RUN is 1 cycle.
REQ-022 On handshake (tvalid=1, tready=1) without a simultaneous load, m_axis_tvalid SHALL drop to 0.
REQ-023 While tvalid=1 and tready=0, tdata, tlast and tvalid SHALL hold stable.
REQ-024 Sustained throughput SHALL be 1 beat per cycle when tready=1 and the FIFO stays non-empty.
REQ-025 A load beat counter (0..PKT_LEN-1) SHALL increment per load and wrap to 0 after loading beat PKT_LEN-1.
REQ-026 m_axis_tlast SHALL be registered with the beat and be 1 exactly for beat index PKT_LEN-1.
REQ-027 With PKT_LEN=1, every beat SHALL carry tlast=1.
REQ-028 If enable falls mid-packet, the block SHALL complete the packet (all PKT_LEN beats) before IDLE, and SHALL load no beat of a next packet once enable=0.
REQ-029 A FIFO underrun mid-packet SHALL deassert tvalid with no filler beats, and loading SHALL resume when fifo_empty=0.
REQ-030 pkt_count SHALL increment by 1 on each tlast handshake and wrap modulo 2^CNT_W.
REQ-031 In IDLE the block SHALL NOT pop, regardless of FIFO occupancy.

Reset
REQ-032 While rst=1 (asynchronous), the block SHALL hold state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pkt_count=0, beat counter=0, busy=0, and fifo_rd_en=0.
REQ-033 A reset mid-packet SHALL discard the word in the output register with no tlast completion; after reset, the first beat loaded SHALL be index 0.

Verification
REQ-034 Bench SHALL cover: PKT_LEN=4, FIFO preloaded with 8 words 0x001..0x008, enable=1, tready=1 -> 8 back-to-back beats, tlast on 0x004 and 0x008, pkt_count=2.
REQ-035 Bench SHALL cover: tready toggled 1/0 every cycle during a 4-beat packet -> no data lost or duplicated, tdata stable while stalled, exactly 4 pops.
REQ-036 Bench SHALL cover: enable dropped after beat 2 of a 4-beat packet, with 10 words in the FIFO -> beats 3 and 4 still sent with tlast on beat 4, then IDLE with 6 words left.
REQ-037 Bench SHALL cover: FIFO empties after beat 1 for 5 cycles -> tvalid=0 for those cycles, fifo_rd_en=0, then the packet resumes with correct tlast position.
REQ-038 Bench SHALL cover: rst pulsed while tvalid=1 at beat 2 -> outputs return to reset values immediately, and the next packet's tlast comes on its 4th beat.
REQ-039 Bench SHALL cover: CNT_W=2 with 5 packets sent -> pkt_count sequence 1, 2, 3, 0, 1.
